// File: rtl/cu_mod0_1.sv
// Control unit for the second radix-2 SDF butterfly stage of the mod0 FFT pipeline.
// Sequences fill/run/drain of the HALF_LEN delay line and tags each output with its twiddle.
module cu_mod0_1 #(
    parameter int FRAME_LEN = 64,
    parameter int HALF_LEN  = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        alert_mod01,
    input  logic                        valid_fac8_0,
    output logic                        bf_en,
    output logic                        valid_fac8_1,
    output logic                        fac_en,
    output logic [$clog2(HALF_LEN)-1:0] tw_idx,
    output logic                        alert_mod02,
    output logic                        busy,
    output logic                        err_ovr
);

    localparam int IW = $clog2(FRAME_LEN);
    localparam int HW = $clog2(HALF_LEN);
    localparam logic [IW-1:0] FILL_LAST = IW'(HALF_LEN - 1);
    localparam logic [IW-1:0] RUN_LAST  = IW'(FRAME_LEN - 1);
    localparam logic [HW-1:0] DR_LAST   = HW'(HALF_LEN - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t        state, state_n;
    logic [IW-1:0] in_cnt;
    logic [IW-1:0] out_cnt;
    logic [HW-1:0] dr_cnt;
    logic          accept;
    logic          emit;
    logic          err_hit;

    logic          vld_p1;
    logic          fac_p1;
    logic [HW-1:0] tw_p1;
    logic          first_p1;
    logic          busy_p1;
    logic          err_p1;

    always_comb begin
        accept  = valid_fac8_0 &&
                  ((state == FILL) || (state == RUN) || ((state == IDLE) && alert_mod01));
        emit    = ((state == RUN) && accept) || (state == DRAIN);
        err_hit = (alert_mod01 && (state != IDLE)) ||
                  (valid_fac8_0 && (state == DRAIN)) ||
                  (valid_fac8_0 && (state == IDLE) && !alert_mod01);

        state_n = state;
        case (state)
            IDLE:    if (alert_mod01) state_n = FILL;
            FILL:    if (accept && (in_cnt == FILL_LAST)) state_n = RUN;
            RUN:     if (accept && (in_cnt == RUN_LAST)) state_n = DRAIN;
            DRAIN:   if (dr_cnt == DR_LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Second half of each span pairs with the delayed first half
    assign bf_en = (state == RUN) && in_cnt[HW];

    // Stage p0 -> p1: counters, FSM and registered output tags
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state    <= IDLE;
            in_cnt   <= '0;
            out_cnt  <= '0;
            dr_cnt   <= '0;
            vld_p1   <= 1'b0;
            fac_p1   <= 1'b0;
            tw_p1    <= '0;
            first_p1 <= 1'b0;
            busy_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            state <= state_n;
            // Held through the final drain cycle so it covers the last output
            busy_p1 <= (state_n != IDLE) || (state == DRAIN);

            if (accept) in_cnt <= in_cnt + IW'(1);

            if ((state == IDLE) && alert_mod01) out_cnt <= '0;
            else if (emit)                      out_cnt <= out_cnt + IW'(1);

            if (state == DRAIN) dr_cnt <= dr_cnt + HW'(1);

            vld_p1   <= emit;
            fac_p1   <= emit && out_cnt[HW];
            tw_p1    <= emit ? out_cnt[HW-1:0] : '0;
            first_p1 <= emit && (out_cnt == '0);

            if (err_hit) err_p1 <= 1'b1;
        end
    end

    assign valid_fac8_1 = vld_p1;
    assign fac_en       = fac_p1;
    assign tw_idx       = tw_p1;
    assign alert_mod02  = first_p1;
    assign busy         = busy_p1;
    assign err_ovr      = err_p1;

endmodule

// File: tb/tb_cu_mod0_1.sv
// Scoreboard bench for cu_mod0_1: driver queues expected outputs per frame,
// a negedge monitor pops and compares whenever valid_fac8_1 is high.
module tb_cu_mod0_1;

    localparam int HW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          alert_mod01;
    logic          valid_fac8_0;
    logic          bf_en;
    logic          valid_fac8_1;
    logic          fac_en;
    logic [HW-1:0] tw_idx;
    logic          alert_mod02;
    logic          busy;
    logic          err_ovr;

    cu_mod0_1 #(.FRAME_LEN(64), .HALF_LEN(8)) dut (
        .clk          (clk),
        .rstn         (rst),
        .alert_mod01  (alert_mod01),
        .valid_fac8_0 (valid_fac8_0),
        .bf_en        (bf_en),
        .valid_fac8_1 (valid_fac8_1),
        .fac_en       (fac_en),
        .tw_idx       (tw_idx),
        .alert_mod02  (alert_mod02),
        .busy         (busy),
        .err_ovr      (err_ovr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          fac;
        logic [HW-1:0] tw;
        logic          al;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   outs = 0;
    int   al_cnt = 0;
    int   busy_cnt = 0;
    int   bf_cnt = 0;
    int   out_cyc[64];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cnt++;
            if (alert_mod02) al_cnt++;
            if (valid_fac8_1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_out: output at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("fac_en", int'(fac_en), int'(e.fac));
                    chk("tw_idx", int'(tw_idx), int'(e.tw));
                    chk("alert_mod02", int'(alert_mod02), int'(e.al));
                end
                if (outs < 64) out_cyc[outs] = cyc;
                outs++;
            end else begin
                chk("quiet_when_invalid", int'({fac_en, tw_idx, alert_mod02}), 0);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bf_en"}, int'(bf_en), 0);
        chk({tag, "_valid"}, int'(valid_fac8_1), 0);
        chk({tag, "_fac_tw"}, int'({fac_en, tw_idx}), 0);
        chk({tag, "_alert"}, int'(alert_mod02), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err"}, int'(err_ovr), 0);
    endtask

    // gap: drop every 3rd cycle; realert_at: sample index to re-pulse alert (-1 none);
    // drain_stray: valid cycles driven into DRAIN; abort_at: sample index to reset at (-1 none)
    task automatic run_frame(input bit gap, input int realert_at, input int drain_stray,
                             input int abort_at, output int c0);
        int s = 0;
        int i = 0;
        int w = 0;
        bit v;
        exp_t x;
        c0 = 0;
        for (int k = 0; k < 64; k++) begin
            x.fac = k[3];
            x.tw  = k[2:0];
            x.al  = (k == 0);
            exp_q.push_back(x);
        end
        outs = 0; al_cnt = 0; busy_cnt = 0; bf_cnt = 0;
        while (s < 64) begin
            @(negedge clk);
            if (s == abort_at) begin
                valid_fac8_0 = 1'b0;
                alert_mod01  = 1'b0;
                #2 rst = 1'b1;
                #1 chk_reset_outputs("mid_reset");
                chk("outs_before_reset", outs, 22);
                exp_q.delete();
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            v = !(gap && (i % 3 == 2));
            valid_fac8_0 = v;
            alert_mod01  = v && ((s == 0) || (s == realert_at));
            if (s == 0) c0 = cyc;
            #1;
            if (v) begin
                chk("bf_en", int'(bf_en), int'(s >= 8 && s[3]));
                if (bf_en) bf_cnt++;
                s++;
            end
            i++;
        end
        for (int d = 0; d < drain_stray; d++) begin
            @(negedge clk);
            valid_fac8_0 = 1'b1;
            alert_mod01  = 1'b0;
        end
        @(negedge clk);
        valid_fac8_0 = 1'b0;
        alert_mod01  = 1'b0;
        while (busy && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (busy) chk("drain_timeout_busy", int'(busy), 0);
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_outputs"}, outs, 64);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
        chk({tag, "_bf_samples"}, bf_cnt, 32);
        chk({tag, "_alert_pulses"}, al_cnt, 1);
        chk({tag, "_drain_consecutive"}, out_cyc[63] - out_cyc[56], 7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b1;
        alert_mod01 = 1'b0;
        valid_fac8_0 = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(1'b0, -1, 0, -1, c0);
        chk_frame("cont");
        chk("cont_busy_cycles", busy_cnt, 72);
        chk("cont_first_out_cycle", out_cyc[0] - c0, 9);
        chk("cont_last_out_cycle", out_cyc[63] - c0, 72);
        chk("cont_err", int'(err_ovr), 0);

        run_frame(1'b1, -1, 0, -1, c0);
        chk_frame("gap");
        chk("gap_err", int'(err_ovr), 0);

        run_frame(1'b0, 20, 0, -1, c0);
        chk_frame("realert");
        chk("realert_err", int'(err_ovr), 1);

        run_frame(1'b0, -1, 0, 30, c0);
        run_frame(1'b0, -1, 0, -1, c0);
        chk_frame("post_reset");
        chk("post_reset_first_out", out_cyc[0] - c0, 9);
        chk("post_reset_err", int'(err_ovr), 0);

        run_frame(1'b0, -1, 2, -1, c0);
        chk_frame("drain_stray");
        chk("drain_stray_last_out", out_cyc[63] - c0, 72);
        chk("drain_stray_err", int'(err_ovr), 1);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        outs = 0;
        valid_fac8_0 = 1'b1;
        @(negedge clk);
        valid_fac8_0 = 1'b0;
        chk("idle_stray_err", int'(err_ovr), 1);
        chk("idle_stray_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        chk("idle_stray_outputs", outs, 0);

        run_frame(1'b0, -1, 0, -1, c0);
        chk_frame("after_idle_stray");
        chk("after_idle_stray_first_out", out_cyc[0] - c0, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
